// File: rtl/mem_arbiter.sv
// Arbitrates the core's single unified memory port between instruction fetch (I) and load/store (D).
// Latency: gnt in the request cycle, mem_req the next cycle, rvalid in the cycle mem_rvalid returns.
// Backpressure: one transaction in flight; requests are ignored while busy; mem_req holds until mem_ready.
//
// Ports:
//   clk, reset                      - rising-edge clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt           - fetch request, accepted by a one-cycle i_gnt pulse
//   i_rvalid/i_rdata                - fetch response
//   d_req/d_we/d_addr/d_wdata/d_be  - load/store request, accepted by a one-cycle d_gnt pulse
//   d_rvalid/d_rdata                - load data or store acknowledge
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be <- mem_ready   - request to memory, held until mem_ready
//   mem_rvalid/mem_rdata            - memory response
//   busy                            - a transaction is in progress
//   protocol_err                    - sticky flag: memory responded when nothing was waiting
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   // instruction fetch port
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   // load/store port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   // unified memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   // status
   output logic                busy,
   output logic                protocol_err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP
   } state_t;

   // Request fields captured at grant time; they drive the memory port
   // unchanged for the whole transaction.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } req_t;

   state_t           state, state_nxt;
   logic             owner_i, owner_i_nxt;     // 1 = I owns the transaction, 0 = D
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;   // consecutive arbitrations I has lost
   req_t             req_q, req_nxt;
   logic             perr_q;

   logic             i_win, d_win;
   logic             i_rv, d_rv;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner_i  <= 1'b0;
         wait_cnt <= '0;
         req_q    <= '0;
      end else begin
         state    <= state_nxt;
         owner_i  <= owner_i_nxt;
         wait_cnt <= wait_cnt_nxt;
         req_q    <= req_nxt;
      end
   end

   // A response with no transaction waiting for it means the memory model
   // and this block have lost sync; flag it until the next reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else if (mem_rvalid && (state != WAIT_RESP)) begin
         perr_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, arbitration and response routing
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      owner_i_nxt  = owner_i;
      wait_cnt_nxt = wait_cnt;
      req_nxt      = req_q;
      i_win        = 1'b0;
      d_win        = 1'b0;
      i_rv         = 1'b0;
      d_rv         = 1'b0;

      case (state)
         IDLE: begin
            // D has fixed priority unless I has already lost MAX_WAIT times in a row.
            i_win = i_req && (!d_req || (wait_cnt == MAX_CNT));
            d_win = d_req && !i_win;

            if (i_win) begin
               owner_i_nxt   = 1'b1;
               req_nxt.we    = 1'b0;
               req_nxt.addr  = i_addr;
               req_nxt.wdata = '0;
               req_nxt.be    = '1;
               wait_cnt_nxt  = '0;
               state_nxt     = ISSUE;
            end else if (d_win) begin
               owner_i_nxt   = 1'b0;
               req_nxt.we    = d_we;
               req_nxt.addr  = d_addr;
               req_nxt.wdata = d_wdata;
               req_nxt.be    = d_be;
               state_nxt     = ISSUE;
               // Only a pending I request counts as a loss; a withdrawn one
               // restarts the starvation window.
               if (i_req) begin
                  wait_cnt_nxt = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + CNT_W'(1);
               end else begin
                  wait_cnt_nxt = '0;
               end
            end else begin
               wait_cnt_nxt = '0;
            end
         end

         ISSUE: begin
            if (mem_ready) begin
               state_nxt = WAIT_RESP;
            end
         end

         WAIT_RESP: begin
            if (mem_rvalid) begin
               i_rv      = owner_i;
               d_rv      = !owner_i;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The FSM sits in IDLE while reset is held, so the combinational grant
   // and data paths are masked to keep every output at zero during reset.
   assign i_gnt        = i_win && !reset;
   assign d_gnt        = d_win && !reset;
   assign i_rvalid     = i_rv && !reset;
   assign d_rvalid     = d_rv && !reset;
   assign i_rdata      = reset ? '0 : mem_rdata;
   assign d_rdata      = reset ? '0 : mem_rdata;

   assign mem_req      = (state == ISSUE);
   assign mem_we       = req_q.we;
   assign mem_addr     = req_q.addr;
   assign mem_wdata    = req_q.wdata;
   assign mem_be       = req_q.be;

   assign busy         = (state != IDLE);
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int BE_W     = DATA_W / 8;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_gnt, i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [BE_W-1:0]   d_be = '0;
   logic              d_gnt, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_ready = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              busy, protocol_err;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Transaction-level model: one transaction at a time, tracked as
   // "nothing pending" / "waiting for memory to accept" / "waiting for data".
   // ------------------------------------------------------------------
   bit                m_pending;     // a granted transaction exists
   bit                m_accepted;    // memory has taken the request
   bit                m_for_i;       // transaction belongs to I
   int                m_losses;      // how many times in a row I lost
   bit                m_err;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [BE_W-1:0]   m_be;

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         m_pending = 0; m_accepted = 0; m_for_i = 0; m_losses = 0; m_err = 0;
         m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      end else begin
         bit e_ig, e_dg, e_irv, e_drv;
         e_ig  = !m_pending && i_req && (!d_req || m_losses >= MAX_WAIT);
         e_dg  = !m_pending && d_req && !e_ig;
         e_irv = m_pending && m_accepted && mem_rvalid && m_for_i;
         e_drv = m_pending && m_accepted && mem_rvalid && !m_for_i;

         chk("m_i_gnt", i_gnt, e_ig);
         chk("m_d_gnt", d_gnt, e_dg);
         chk("m_i_rvalid", i_rvalid, e_irv);
         chk("m_d_rvalid", d_rvalid, e_drv);
         if (e_irv) chk("m_i_rdata", i_rdata, mem_rdata);
         if (e_drv) chk("m_d_rdata", d_rdata, mem_rdata);
         chk("m_busy", busy, m_pending);
         chk("m_mem_req", mem_req, m_pending && !m_accepted);
         if (m_pending && !m_accepted) begin
            chk("m_mem_we", mem_we, m_we);
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_mem_be", mem_be, m_be);
         end
         chk("m_protocol_err", protocol_err, m_err);

         // advance to what the next clock edge produces
         if (mem_rvalid && !(m_pending && m_accepted)) m_err = 1;
         if (!m_pending) begin
            if (!i_req) m_losses = 0;
            else if (e_ig) m_losses = 0;
            else if (e_dg) m_losses = (m_losses + 1 > MAX_WAIT) ? MAX_WAIT : m_losses + 1;
            if (e_ig) begin
               m_pending = 1; m_accepted = 0; m_for_i = 1;
               m_we = 0; m_addr = i_addr; m_wdata = '0; m_be = '1;
            end else if (e_dg) begin
               m_pending = 1; m_accepted = 0; m_for_i = 0;
               m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
            end
         end else if (!m_accepted) begin
            if (mem_ready) m_accepted = 1;
         end else if (mem_rvalid) begin
            m_pending = 0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // One minimum-latency transaction: grant, accept, respond.
   task automatic txn(input bit ir, input bit dr, input bit exp_i, input int n);
      logic [ADDR_W-1:0] ea;
      i_req = ir; d_req = dr; d_we = 0;
      i_addr = 32'h400 + n; d_addr = 32'h300 + n;
      mem_ready = 0; mem_rvalid = 0;
      ea = exp_i ? 32'h400 + n : 32'h300 + n;
      look();
      chk($sformatf("gnt%0d_i", n), i_gnt, exp_i);
      chk($sformatf("gnt%0d_d", n), d_gnt, !exp_i);
      step();
      mem_ready = 1;
      look();
      chk($sformatf("txn%0d_addr", n), mem_addr, ea);
      step();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA000 + n;
      look();
      chk($sformatf("txn%0d_irv", n), i_rvalid, exp_i);
      chk($sformatf("txn%0d_drv", n), d_rvalid, !exp_i);
      step();
      mem_rvalid = 0;
   endtask

   initial begin
      // reset state
      look();
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_perr", protocol_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      step();
      reset = 0;

      // single I read
      i_req = 1; i_addr = 32'h100;
      look();
      chk("ird_i_gnt", i_gnt, 1);
      chk("ird_d_gnt", d_gnt, 0);
      chk("ird_mem_req0", mem_req, 0);
      step();
      i_req = 0; mem_ready = 1;
      look();
      chk("ird_mem_req", mem_req, 1);
      chk("ird_mem_addr", mem_addr, 32'h100);
      chk("ird_mem_be", mem_be, 4'hF);
      chk("ird_mem_we", mem_we, 0);
      chk("ird_no_gnt", i_gnt, 0);
      step();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      look();
      chk("ird_i_rvalid", i_rvalid, 1);
      chk("ird_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("ird_d_rvalid", d_rvalid, 0);
      step();
      mem_rvalid = 0;
      look();
      chk("ird_idle", busy, 0);

      // D store with memory stalling three cycles
      step();
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
      look();
      chk("st_d_gnt", d_gnt, 1);
      step();
      d_req = 0; d_we = 0; d_addr = 32'hFFF; d_wdata = '0; d_be = 4'hF;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         look();
         chk($sformatf("st_req%0d", k), mem_req, 1);
         chk($sformatf("st_addr%0d", k), mem_addr, 32'h200);
         chk($sformatf("st_wdata%0d", k), mem_wdata, 32'h12345678);
         chk($sformatf("st_be%0d", k), mem_be, 4'h3);
         chk($sformatf("st_we%0d", k), mem_we, 1);
         chk($sformatf("st_busy%0d", k), busy, 1);
         step();
      end
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0;
      look();
      chk("st_d_rvalid", d_rvalid, 1);
      chk("st_i_rvalid", i_rvalid, 0);
      chk("st_busy_ack", busy, 1);
      step();
      mem_rvalid = 0;

      // sustained contention: D,D,D,D,I,D,D,D,D,I
      for (int n = 0; n < 10; n++) txn(1, 1, (n == 4 || n == 9), n);

      // I withdraws after two losses: the starvation count restarts
      txn(1, 1, 0, 20);
      txn(1, 1, 0, 21);
      txn(0, 1, 0, 22);
      for (int n = 0; n < 5; n++) txn(1, 1, (n == 4), 30 + n);
      i_req = 0; d_req = 0;

      // stray response while idle
      step();
      mem_rvalid = 1; mem_rdata = 32'h5555;
      look();
      chk("stray_i_rvalid", i_rvalid, 0);
      chk("stray_d_rvalid", d_rvalid, 0);
      chk("stray_perr_before", protocol_err, 0);
      step();
      mem_rvalid = 0;
      look();
      chk("stray_perr_set", protocol_err, 1);
      step();
      txn(1, 0, 1, 40);
      i_req = 0;
      look();
      chk("stray_perr_sticky", protocol_err, 1);

      // reset while waiting for a response
      step();
      d_req = 1; d_we = 0; d_addr = 32'h500;
      look();
      step();
      d_req = 0; mem_ready = 1;
      look();
      step();
      mem_ready = 0;
      look();
      chk("rw_busy_before", busy, 1);
      #2;
      reset = 1;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_mem_req", mem_req, 0);
      chk("rw_mem_addr", mem_addr, 0);
      chk("rw_perr", protocol_err, 0);
      chk("rw_d_rvalid", d_rvalid, 0);
      step();
      reset = 0;
      i_req = 1; i_addr = 32'h600;
      look();
      chk("rw_i_gnt", i_gnt, 1);
      step();
      i_req = 0; mem_ready = 1;
      look();
      chk("rw_mem_addr2", mem_addr, 32'h600);
      step();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
      look();
      chk("rw_i_rvalid", i_rvalid, 1);
      chk("rw_i_rdata", i_rdata, 32'hCAFE0001);
      chk("rw_perr_after", protocol_err, 0);
      step();
      mem_rvalid = 0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified memory port of the core between the instruction-fetch requester (I) and the load/store requester (D). One transaction is outstanding at a time. D has fixed priority; a starvation counter bounds how long I can wait. The block sits between the core pipeline and the unified memory model inside top.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte enables are DATA_W/8 wide
MAX_WAIT, 4, consecutive I-losses after which I wins the next arbitration (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  instruction read request, held until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  one-cycle pulse: I request accepted
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DATA_W  fetch data
d_req  in  1  data request, held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_gnt  out  1  one-cycle pulse: D request accepted
d_rvalid  out  1  one-cycle pulse: load data valid / store acknowledged
d_rdata  out  DATA_W  load data
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables (all ones for I reads)
mem_ready  in  1  memory accepted request this cycle
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  DATA_W  read data
busy  out  1  FSM not in IDLE
protocol_err  out  1  sticky: mem_rvalid outside WAIT_RESP

Behaviour:
- Reset (async, immediate): FSM=IDLE, owner=D, wait_cnt=0, latched request fields=0, protocol_err=0; all outputs 0. Any in-flight transaction is discarded.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE: if neither request, stay. Otherwise choose winner: I if i_req && (!d_req || wait_cnt==MAX_WAIT), else D. Winner's gnt is asserted combinationally in this cycle; request fields latched (I: we=0, be=all ones, wdata=0); owner registered; next state ISSUE.
- wait_cnt (width clog2(MAX_WAIT+1)): in IDLE, +1 (saturating at MAX_WAIT) when i_req && D wins; cleared when I wins or when i_req=0 in IDLE; unchanged in other states.
- ISSUE: mem_req=1 with latched fields stable; on mem_ready=1 -> WAIT_RESP. mem_ready in the same cycle as mem_req is legal.
- WAIT_RESP: on mem_rvalid=1, owner's rvalid=1 combinationally that cycle, owner's rdata=mem_rdata; next state IDLE. Non-owner rvalid stays 0. i_rdata/d_rdata are don't-care when their rvalid=0 (drive mem_rdata).
- Minimum throughput: gnt cycle N, mem_req N+1 (ready N+1), rvalid N+2, next gnt N+3.
- Requests arriving while busy are ignored until IDLE; requesters must hold req. gnt never asserts outside IDLE.
- mem_rvalid in IDLE or ISSUE: ignored for routing, sets protocol_err (cleared only by reset).
- Simultaneous i_req/d_req with wait_cnt<MAX_WAIT: D wins; with wait_cnt==MAX_WAIT: I wins, counter clears.
- busy = (state != IDLE).

Test Plan:
- Single I read, addr 0x100, mem_ready immediate, rvalid next cycle with 0xDEADBEEF -> i_gnt cycle 0, mem_req/addr 0x100/be 0xF cycle 1, i_rvalid/i_rdata 0xDEADBEEF cycle 2, d_rvalid never.
- D store addr 0x200, wdata 0x12345678, be 0x3, mem_ready delayed 3 cycles -> mem_req held 4 cycles with stable fields, mem_we=1, d_rvalid on ack, busy high throughout.
- Both requests held continuously, MAX_WAIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; wait_cnt saturates at 4 then clears.
- i_req drops in IDLE after 2 losses -> wait_cnt clears to 0; later contention needs 4 fresh losses before I wins.
- Stray mem_rvalid while IDLE -> no rvalid on either port, protocol_err=1 and stays set until reset.
- Reset asserted in WAIT_RESP -> outputs 0 immediately, state IDLE after release, next i_req granted normally, protocol_err=0.
